// File: rtl/sram_arbiter_pkg.sv
// Shared types for the IF/LSU sram arbiter.
// FSM state and owner encodings plus small helpers.
package sram_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_WAIT = 2'd1,
    ARB_RESP = 2'd2
  } arb_state_e;

  typedef enum logic {
    ARB_OWN_IF = 1'b0,
    ARB_OWN_LS = 1'b1
  } arb_owner_e;

  function automatic arb_owner_e other_port(
    input arb_owner_e o
  );
    return (o == ARB_OWN_IF) ? ARB_OWN_LS : ARB_OWN_IF;
  endfunction

endpackage

// File: rtl/sram_arb_grant.sv
// Combinational grant/owner select for the sram arbiter.
// Optional round-robin pointer under `SRAM_ARB_RR_EN.
module sram_arb_grant
  import sram_arbiter_pkg::*;
(
`ifdef SRAM_ARB_RR_EN
  input  logic       clk,
  input  logic       rst,
`endif
  input  logic       en,
  input  logic       if_valid,
  input  logic       ls_valid,
  output logic       if_gnt,
  output logic       ls_gnt,
  output arb_owner_e owner
);

  arb_owner_e win;

`ifdef SRAM_ARB_RR_EN
  arb_owner_e rr_q;

  // Preference flips only when both ports contend for a grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_q <= ARB_OWN_IF;
    end else if (en && if_valid && ls_valid) begin
      rr_q <= other_port(rr_q);
    end
  end

  // Lone requester always wins; ties go to the pointer.
  always_comb begin
    win = ARB_OWN_IF;
    unique case (1'b1)
      (if_valid && ls_valid): win = rr_q;
      ls_valid:               win = ARB_OWN_LS;
      default:                win = ARB_OWN_IF;
    endcase
  end
`else
  // Fixed priority: LS beats IF.
  always_comb begin
    win = ls_valid ? ARB_OWN_LS : ARB_OWN_IF;
  end
`endif

  assign if_gnt = en && if_valid &&
                  (win == ARB_OWN_IF);
  assign ls_gnt = en && ls_valid &&
                  (win == ARB_OWN_LS);
  assign owner  = win;

endmodule

// File: rtl/sram_arbiter.sv
// Single-port sram arbiter between IF (read) and LSU (r/w).
// Define SRAM_ARB_RR_EN for round-robin instead of LS priority.
module sram_arbiter
  import sram_arbiter_pkg::*;
#(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req_valid,
  output logic              if_req_ready,
  input  logic [ADDR_W-1:0] if_req_addr,
  output logic              if_rsp_valid,
  input  logic              if_rsp_ready,
  output logic [DATA_W-1:0] if_rsp_rdata,
  input  logic              ls_req_valid,
  output logic              ls_req_ready,
  input  logic [ADDR_W-1:0] ls_req_addr,
  input  logic [DATA_W/8-1:0] ls_req_we,
  input  logic [DATA_W-1:0] ls_req_wdata,
  output logic              ls_rsp_valid,
  input  logic              ls_rsp_ready,
  output logic [DATA_W-1:0] ls_rsp_rdata,
  output logic              sram_en,
  output logic [DATA_W/8-1:0] sram_we,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata
);

  arb_state_e        state_q;
  arb_owner_e        owner_q;
  arb_owner_e        gnt_owner;
  logic              wr_q;
  logic [DATA_W-1:0] rsp_buf_q;
  logic              if_rsp_valid_q;
  logic              ls_rsp_valid_q;
  logic              grant_en;
  logic              if_gnt;
  logic              ls_gnt;
  logic              rsp_fire;

  // Grants only open in IDLE, and never while reset is held.
  assign grant_en = (state_q == ARB_IDLE) && !rst;

  sram_arb_grant u_grant (
`ifdef SRAM_ARB_RR_EN
    .clk      (clk),
    .rst      (rst),
`endif
    .en       (grant_en),
    .if_valid (if_req_valid),
    .ls_valid (ls_req_valid),
    .if_gnt   (if_gnt),
    .ls_gnt   (ls_gnt),
    .owner    (gnt_owner)
  );

  assign if_req_ready = if_gnt;
  assign ls_req_ready = ls_gnt;

  assign sram_en    = if_gnt | ls_gnt;
  assign sram_addr  = if_gnt ? if_req_addr
                             : ls_req_addr;
  assign sram_we    = ls_gnt ? ls_req_we : '0;
  assign sram_wdata = ls_req_wdata;

  assign rsp_fire = (if_rsp_valid_q && if_rsp_ready) ||
                    (ls_rsp_valid_q && ls_rsp_ready);

  assign if_rsp_valid = if_rsp_valid_q;
  assign ls_rsp_valid = ls_rsp_valid_q;
  assign if_rsp_rdata = (owner_q == ARB_OWN_IF) ?
                        rsp_buf_q : '0;
  assign ls_rsp_rdata = (owner_q == ARB_OWN_LS) ?
                        rsp_buf_q : '0;

  // Transaction FSM with registered response buffer/valids.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ARB_IDLE;
      owner_q        <= ARB_OWN_LS;
      wr_q           <= 1'b0;
      rsp_buf_q      <= '0;
      if_rsp_valid_q <= 1'b0;
      ls_rsp_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        ARB_IDLE: begin
          if (sram_en) begin
            owner_q <= gnt_owner;
            wr_q    <= |sram_we;
            state_q <= ARB_WAIT;
          end
        end
        ARB_WAIT: begin
          rsp_buf_q      <= wr_q ? '0 : sram_rdata;
          if_rsp_valid_q <= (owner_q == ARB_OWN_IF);
          ls_rsp_valid_q <= (owner_q == ARB_OWN_LS);
          state_q        <= ARB_RESP;
        end
        ARB_RESP: begin
          if (rsp_fire) begin
            if_rsp_valid_q <= 1'b0;
            ls_rsp_valid_q <= 1'b0;
            state_q        <= ARB_IDLE;
          end
        end
        default: state_q <= ARB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Randomized bench for sram_arbiter against a
// transaction-level reference model of the arbiter.
module tb_sram_arbiter;

  localparam logic [63:0] PC_START = 64'h8000_0000;
`ifdef SRAM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req_valid, if_req_ready;
  logic [63:0] if_req_addr;
  logic        if_rsp_valid, if_rsp_ready;
  logic [63:0] if_rsp_rdata;
  logic        ls_req_valid, ls_req_ready;
  logic [63:0] ls_req_addr;
  logic [7:0]  ls_req_we;
  logic [63:0] ls_req_wdata;
  logic        ls_rsp_valid, ls_rsp_ready;
  logic [63:0] ls_rsp_rdata;
  logic        sram_en;
  logic [7:0]  sram_we;
  logic [63:0] sram_addr, sram_wdata;
  logic [63:0] sram_rdata = '0;

  always #5 clk = ~clk;

  sram_arbiter dut (
    .clk          (clk),
    .rst          (rst),
    .if_req_valid (if_req_valid),
    .if_req_ready (if_req_ready),
    .if_req_addr  (if_req_addr),
    .if_rsp_valid (if_rsp_valid),
    .if_rsp_ready (if_rsp_ready),
    .if_rsp_rdata (if_rsp_rdata),
    .ls_req_valid (ls_req_valid),
    .ls_req_ready (ls_req_ready),
    .ls_req_addr  (ls_req_addr),
    .ls_req_we    (ls_req_we),
    .ls_req_wdata (ls_req_wdata),
    .ls_rsp_valid (ls_rsp_valid),
    .ls_rsp_ready (ls_rsp_ready),
    .ls_rsp_rdata (ls_rsp_rdata),
    .sram_en      (sram_en),
    .sram_we      (sram_we),
    .sram_addr    (sram_addr),
    .sram_wdata   (sram_wdata),
    .sram_rdata   (sram_rdata)
  );

  function automatic logic [63:0] init_word(
    input logic [60:0] i
  );
    return {3'b000, i} ^ 64'hC3A5_0F1E_9B7D_2468;
  endfunction

  // Environment sram: registered read, byte writes.
  logic [63:0] sram_mem [logic [60:0]];
  always @(posedge clk) begin : sram_model
    logic [63:0] w;
    logic [60:0] ix;
    if (sram_en) begin
      ix = sram_addr[63:3];
      w = sram_mem.exists(ix) ? sram_mem[ix]
                              : init_word(ix);
      sram_rdata <= w;
      for (int b = 0; b < 8; b++)
        if (sram_we[b]) w[8*b +: 8] = sram_wdata[8*b +: 8];
      if (|sram_we) sram_mem[ix] = w;
    end
  end

  // Reference model state.
  logic [63:0] ref_mem [logic [60:0]];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  bit          busy = 0;
  int          age = 0;
  bit          own_ls = 0;
  logic [63:0] exp_data = '0;
  bit          pref_if = 1;
  bit          g_if = 0;
  bit          g_ls = 0;
  int          gnt_cyc = 0;
  logic [63:0] last_rdata = '0;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)",
               tag, got, exp, cyc);
    end
  endtask

  // One clock: check DUT at negedge against model, then advance.
  task automatic step();
    logic [63:0] a, w;
    logic [60:0] ix;
    bit wi, wl;
    @(negedge clk);
    g_if = 0;
    g_ls = 0;
    if (rst) begin
      chk("rst_if_rdy", 64'(if_req_ready), 0);
      chk("rst_ls_rdy", 64'(ls_req_ready), 0);
      chk("rst_en", 64'(sram_en), 0);
      busy = 0;
      pref_if = 1;
    end else if (!busy) begin
      wi = if_req_valid &&
           (!ls_req_valid || (RR && pref_if));
      wl = ls_req_valid && !wi;
      if (RR && if_req_valid && ls_req_valid)
        pref_if = !pref_if;
      chk("idle_if_rdy", 64'(if_req_ready), 64'(wi));
      chk("idle_ls_rdy", 64'(ls_req_ready), 64'(wl));
      chk("idle_en", 64'(sram_en), 64'(wi | wl));
      chk("idle_if_rspv", 64'(if_rsp_valid), 0);
      chk("idle_ls_rspv", 64'(ls_rsp_valid), 0);
      if (wi || wl) begin
        a = wi ? if_req_addr : ls_req_addr;
        chk("gnt_addr", sram_addr, a);
        chk("gnt_we", 64'(sram_we),
            wl ? 64'(ls_req_we) : 64'h0);
        ix = a[63:3];
        w = ref_mem.exists(ix) ? ref_mem[ix]
                               : init_word(ix);
        if (wl && |ls_req_we) begin
          chk("gnt_wdata", sram_wdata, ls_req_wdata);
          for (int b = 0; b < 8; b++)
            if (ls_req_we[b])
              w[8*b +: 8] = ls_req_wdata[8*b +: 8];
          ref_mem[ix] = w;
          exp_data = '0;
        end else begin
          exp_data = w;
        end
        busy = 1;
        age = 0;
        own_ls = wl;
        gnt_cyc = cyc;
      end
      g_if = wi;
      g_ls = wl;
    end else begin
      age++;
      chk("busy_if_rdy", 64'(if_req_ready), 0);
      chk("busy_ls_rdy", 64'(ls_req_ready), 0);
      chk("busy_en", 64'(sram_en), 0);
      if (age == 1) begin
        chk("wait_if_rspv", 64'(if_rsp_valid), 0);
        chk("wait_ls_rspv", 64'(ls_rsp_valid), 0);
      end else begin
        chk("rsp_if_v", 64'(if_rsp_valid), 64'(!own_ls));
        chk("rsp_ls_v", 64'(ls_rsp_valid), 64'(own_ls));
        if (own_ls) begin
          chk("rsp_ls_data", ls_rsp_rdata, exp_data);
          chk("rsp_if_zero", if_rsp_rdata, 0);
          last_rdata = ls_rsp_rdata;
          if (ls_rsp_ready) busy = 0;
        end else begin
          chk("rsp_if_data", if_rsp_rdata, exp_data);
          chk("rsp_ls_zero", ls_rsp_rdata, 0);
          last_rdata = if_rsp_rdata;
          if (if_rsp_ready) busy = 0;
        end
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 30) begin
      step();
      n++;
    end
    if (busy) chk("rsp_timeout", 64'(busy), 0);
  endtask

  task automatic do_req(input bit ls,
                        input logic [63:0] a,
                        input logic [7:0] we,
                        input logic [63:0] wd);
    int n = 0;
    if (ls) begin
      ls_req_valid = 1; ls_req_addr = a;
      ls_req_we = we; ls_req_wdata = wd;
    end else begin
      if_req_valid = 1; if_req_addr = a;
    end
    do begin
      step();
      n++;
    end while (!(ls ? g_ls : g_if) && n < 30);
    if (!(ls ? g_ls : g_if)) chk("gnt_timeout", 0, 1);
    if (ls) ls_req_valid = 0;
    else if_req_valid = 0;
  endtask

  task automatic do_reset();
    rst = 1;
    step();
    rst = 0;
  endtask

  function automatic logic [63:0] rnd_addr();
    return PC_START + 64'($urandom_range(0, 127));
  endfunction

  initial begin : main
    logic [63:0] a;
    int c0, c1, n;
    bit first_ls;
    logic [3:0] seq;
    rst = 1;
    if_req_valid = 0; if_req_addr = '0;
    ls_req_valid = 0; ls_req_addr = '0;
    ls_req_we = '0; ls_req_wdata = '0;
    if_rsp_ready = 1; ls_rsp_ready = 1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_if_rspv", 64'(if_rsp_valid), 0);
    chk("rst_ls_rspv", 64'(ls_rsp_valid), 0);
    chk("rst_if_rdata", if_rsp_rdata, 0);
    chk("rst_ls_rdata", ls_rsp_rdata, 0);
    chk("rst_sram_we", 64'(sram_we), 0);
    step();
    rst = 0;

    // 1: IF read with known word.
    a = PC_START + 64'h10;
    sram_mem[a[63:3]] = 64'hDEAD_BEEF_0000_0001;
    ref_mem[a[63:3]]  = 64'hDEAD_BEEF_0000_0001;
    do_req(0, a, 8'h00, 64'h0);
    wait_idle();
    chk("t1_rdata", last_rdata, 64'hDEAD_BEEF_0000_0001);

    // 2: partial write then read back.
    a = PC_START + 64'h208;
    do_req(1, a, 8'h0F, 64'h1111_2222_3333_4444);
    wait_idle();
    chk("t2_wr_rdata", last_rdata, 0);
    do_req(1, a, 8'h00, 64'h0);
    wait_idle();
    chk("t2_rd_rdata", last_rdata,
        {init_word(a[63:3]) >> 32, 32'h3333_4444} & 64'hFFFF_FFFF_FFFF_FFFF);

    // 3: simultaneous requests.
    do_reset();
    if_req_valid = 1; if_req_addr = PC_START;
    ls_req_valid = 1; ls_req_addr = PC_START + 64'h40;
    ls_req_we = '0;
    n = 0; c0 = -1; c1 = -1; first_ls = 0;
    while ((if_req_valid || ls_req_valid) && n < 40) begin
      step();
      n++;
      if (g_if || g_ls) begin
        if (c0 < 0) begin
          c0 = gnt_cyc; first_ls = g_ls;
        end else c1 = gnt_cyc;
      end
      if (g_if) if_req_valid = 0;
      if (g_ls) ls_req_valid = 0;
    end
    wait_idle();
    chk("t3_first_ls", 64'(first_ls), 64'(!RR));
    chk("t3_gap", 64'(c1 - c0), 3);

    // 3b: four grants under continuous contention.
    if_req_valid = 1; ls_req_valid = 1;
    n = 0; c0 = 0; seq = '0;
    while (c0 < 4 && n < 40) begin
      step();
      n++;
      if (g_if || g_ls) begin
        seq[c0] = g_ls;
        c0++;
      end
    end
    if_req_valid = 0; ls_req_valid = 0;
    wait_idle();
    chk("t3_seq", 64'(seq), RR ? 64'h5 : 64'hF);

    // 4: response backpressure with a competing request.
    ls_rsp_ready = 0;
    do_req(1, PC_START + 64'h18, 8'h00, 64'h0);
    if_req_valid = 1; if_req_addr = PC_START + 64'h20;
    repeat (6) step();
    chk("t4_still_busy", 64'(busy), 1);
    ls_rsp_ready = 1;
    wait_idle();
    n = 0;
    while (!g_if && n < 10) begin
      step();
      n++;
    end
    chk("t4_if_gnt", 64'(g_if), 1);
    if_req_valid = 0;
    wait_idle();

    // 5: reset while in WAIT.
    do_req(0, PC_START + 64'h30, 8'h00, 64'h0);
    do_reset();
    chk("t5_if_rspv", 64'(if_rsp_valid), 0);
    chk("t5_ls_rspv", 64'(ls_rsp_valid), 0);
    step();
    do_req(0, PC_START + 64'h30, 8'h00, 64'h0);
    wait_idle();
    chk("t5_rdata", last_rdata,
        init_word(61'((PC_START + 64'h30) >> 3)));

    // 6: back-to-back IF with ready held.
    if_req_valid = 1; if_req_addr = PC_START + 64'h8;
    c0 = -1;
    for (int i = 0; i < 12; i++) begin
      step();
      if (g_if) begin
        if (c0 >= 0) chk("t6_gap", 64'(gnt_cyc - c0), 3);
        c0 = gnt_cyc;
      end
    end
    if_req_valid = 0;
    wait_idle();

    // Random traffic.
    for (int i = 0; i < 1500; i++) begin
      if (!if_req_valid || g_if) begin
        if_req_valid = ($urandom_range(0, 2) == 0);
        if_req_addr = rnd_addr();
      end
      if (!ls_req_valid || g_ls) begin
        ls_req_valid = ($urandom_range(0, 2) == 0);
        ls_req_addr = rnd_addr();
        ls_req_we = $urandom_range(0, 1) ? 8'h00
                                         : 8'($urandom);
        ls_req_wdata = {$urandom, $urandom};
      end
      if_rsp_ready = $urandom_range(0, 1) == 1;
      ls_rsp_ready = $urandom_range(0, 1) == 1;
      if (i == 700) rst = 1;
      else rst = 0;
      step();
    end
    rst = 0;
    if_req_valid = 0; ls_req_valid = 0;
    if_rsp_ready = 1; ls_rsp_ready = 1;
    wait_idle();

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
